// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one data-memory/IO port (M0 = LSU, M1 = debug/DMA), with locked RMW.
// Optional M1 anti-starvation guard is built when ARB_STARVE_GUARD_EN is defined (threshold MAX_WAIT).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic                m0_lock_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_bmask_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic                m1_lock_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_bmask_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_bmask_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be within 1..255");
  end

  typedef enum logic [1:0] {ARB, LOCK_M0, LOCK_M1} state_t;

  state_t state, state_next;
  logic   sel0, sel1;
  logic   starve;
  logic   pend_valid;
  logic   pend_owner;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] wait_cnt;

  assign starve = (wait_cnt >= 8'(MAX_WAIT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (m1_gnt_o) begin
      wait_cnt <= '0;
    end else if (state == ARB && m1_req_i && wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Reset masks selection so nothing reaches the bus while rst_i is high.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (!rst_i) begin
      case (state)
        LOCK_M0: sel0 = m0_req_i;
        LOCK_M1: sel1 = m1_req_i;
        default: begin
          if (m0_req_i && m1_req_i) begin
            sel0 = !starve;
            sel1 = starve;
          end else begin
            sel0 = m0_req_i;
            sel1 = m1_req_i;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_req_o   = sel0 | sel1;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_bmask_o = '0;
    if (sel0) begin
      mem_we_o    = m0_we_i;
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
      mem_bmask_o = m0_bmask_i;
    end else if (sel1) begin
      mem_we_o    = m1_we_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_bmask_o = m1_bmask_i;
    end
  end

  assign m0_gnt_o = sel0 & mem_ready_i;
  assign m1_gnt_o = sel1 & mem_ready_i;

  always_comb begin
    state_next = state;
    if (m0_gnt_o) begin
      state_next = m0_lock_i ? LOCK_M0 : ARB;
    end else if (m1_gnt_o) begin
      state_next = m1_lock_i ? LOCK_M1 : ARB;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ARB;
      pend_valid <= 1'b0;
      pend_owner <= 1'b0;
    end else begin
      state      <= state_next;
      pend_valid <= (m0_gnt_o && !m0_we_i) || (m1_gnt_o && !m1_we_i);
      pend_owner <= m1_gnt_o;
    end
  end

  // A response registered just before reset is dropped while reset is held.
  assign m0_rvalid_o = pend_valid && !pend_owner && !rst_i;
  assign m1_rvalid_o = pend_valid && pend_owner && !rst_i;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of ownership, locking and read responses.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk, rst;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [3:0]    m0_bmask, m1_bmask, mem_bmask;
  logic          mem_req, mem_we, mem_ready;

  int cmp = 0;
  int err = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_bmask_i(m0_bmask), .m0_gnt_o(m0_gnt),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_bmask_i(m1_bmask), .m1_gnt_o(m1_gnt),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_bmask_o(mem_bmask),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, we, lock, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] bm);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = a; m0_wdata = d; m0_bmask = bm;
  endtask

  task automatic set_m1(input logic req, we, lock, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] bm);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = a; m1_wdata = d; m1_bmask = bm;
  endtask

  task automatic clear_reqs();
    set_m0(0, 0, 0, '0, '0, '0);
    set_m1(0, 0, 0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    set_m0(1, 0, 0, 32'h44, '0, 4'hF);
    step(); step();
    #3;
    cmp++; if ({m0_gnt, m1_gnt, mem_req, mem_we} !== 4'b0) begin
      err++; $display("FAIL reset_ctl got %b exp 0000", {m0_gnt, m1_gnt, mem_req, mem_we});
    end
    cmp++; if ({mem_addr, mem_wdata, mem_bmask} !== '0) begin
      err++; $display("FAIL reset_fields got %h exp 0", {mem_addr, mem_wdata, mem_bmask});
    end
    cmp++; if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      err++; $display("FAIL reset_resp got %h exp 0", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata});
    end
    clear_reqs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    mem_ready = 1'b1;
    set_m0(1, 0, 0, 32'h1000, '0, 4'hF);
    #3;
    cmp++; if ({m0_gnt, m1_gnt, mem_req, mem_we} !== 4'b1010) begin
      err++; $display("FAIL single_gnt got %b exp 1010", {m0_gnt, m1_gnt, mem_req, mem_we});
    end
    cmp++; if (mem_addr !== 32'h1000) begin
      err++; $display("FAIL single_addr got %h exp 00001000", mem_addr);
    end
    step();
    clear_reqs();
    mem_rdata = 32'hDEAD_BEEF;
    #3;
    cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== '0) begin
      err++; $display("FAIL single_resp got rv=%b d0=%h d1=%h exp rv=10 d0=deadbeef d1=0",
                      {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
    end
    step();
  endtask

  task automatic test_priority();
    logic exp1;
    mem_ready = 1'b1;
    set_m0(1, 0, 0, 32'h10, '0, 4'hF);
    set_m1(1, 0, 0, 32'h20, '0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      #3;
      exp1 = GUARD && (c == MAXW);
      cmp++; if ({m0_gnt, m1_gnt} !== {!exp1, exp1}) begin
        err++; $display("FAIL priority_c%0d got %b exp %b", c, {m0_gnt, m1_gnt}, {!exp1, exp1});
      end
      step();
    end
    clear_reqs();
    step();
  endtask

  task automatic test_ready_stall();
    set_m1(1, 1, 0, 32'h2000, 32'h55, 4'hF);
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      #3;
      cmp++; if ({m0_gnt, m1_gnt, mem_req, mem_we} !== {1'b0, c == 3, 2'b11}) begin
        err++; $display("FAIL stall_ctl_c%0d got %b exp %b", c, {m0_gnt, m1_gnt, mem_req, mem_we},
                        {1'b0, c == 3, 2'b11});
      end
      cmp++; if ({mem_addr, mem_wdata, mem_bmask} !== {32'h2000, 32'h55, 4'hF}) begin
        err++; $display("FAIL stall_fields_c%0d got %h exp %h", c, {mem_addr, mem_wdata, mem_bmask},
                        {32'h2000, 32'h55, 4'hF});
      end
      step();
    end
    clear_reqs();
    #3;
    cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      err++; $display("FAIL stall_noresp got %b exp 00", {m0_rvalid, m1_rvalid});
    end
    step();
  endtask

  task automatic test_lock();
    mem_ready = 1'b1;
    set_m1(1, 0, 1, 32'h300, '0, 4'hF);
    #3;
    cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin
      err++; $display("FAIL lock_take got %b exp 01", {m0_gnt, m1_gnt});
    end
    step();
    set_m1(0, 0, 0, '0, '0, '0);
    set_m0(1, 0, 0, 32'h400, '0, 4'h3);
    mem_rdata = 32'hA5A5_0001;
    #3;
    cmp++; if ({m0_gnt, m1_gnt, mem_req} !== 3'b000) begin
      err++; $display("FAIL lock_hold got %b exp 000", {m0_gnt, m1_gnt, mem_req});
    end
    cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hA5A5_0001) begin
      err++; $display("FAIL lock_resp got rv=%b d1=%h exp rv=01 d1=a5a50001", {m0_rvalid, m1_rvalid}, m1_rdata);
    end
    step();
    set_m1(1, 1, 0, 32'h304, 32'h77, 4'hF);
    #3;
    cmp++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b011) begin
      err++; $display("FAIL lock_release got %b exp 011", {m0_gnt, m1_gnt, mem_we});
    end
    step();
    set_m1(0, 0, 0, '0, '0, '0);
    #3;
    cmp++; if ({m0_gnt, m1_gnt} !== 2'b10 || mem_addr !== 32'h400) begin
      err++; $display("FAIL lock_after got gnt=%b addr=%h exp gnt=10 addr=00000400", {m0_gnt, m1_gnt}, mem_addr);
    end
    step();
    clear_reqs();
    step();
  endtask

  task automatic test_alternate();
    int owners[4] = '{0, 1, 0, -1};
    int prev = -1;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      clear_reqs();
      if (owners[c] == 0) set_m0(1, 0, 0, 32'h800 + c, '0, 4'hF);
      if (owners[c] == 1) set_m1(1, 0, 0, 32'h900 + c, '0, 4'hF);
      mem_rdata = $urandom;
      #3;
      cmp++; if ({m0_gnt, m1_gnt} !== {owners[c] == 0, owners[c] == 1}) begin
        err++; $display("FAIL alt_gnt_c%0d got %b exp %b", c, {m0_gnt, m1_gnt}, {owners[c] == 0, owners[c] == 1});
      end
      cmp++; if ({m0_rvalid, m1_rvalid} !== {prev == 0, prev == 1} ||
                 m0_rdata !== ((prev == 0) ? mem_rdata : '0) ||
                 m1_rdata !== ((prev == 1) ? mem_rdata : '0)) begin
        err++; $display("FAIL alt_resp_c%0d got rv=%b d0=%h d1=%h exp rv=%b data=%h", c,
                        {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {prev == 0, prev == 1}, mem_rdata);
      end
      prev = owners[c];
      step();
    end
  endtask

  task automatic test_reset_mid_lock();
    mem_ready = 1'b1;
    set_m0(1, 0, 1, 32'h500, '0, 4'hF);
    #3;
    cmp++; if (m0_gnt !== 1'b1) begin
      err++; $display("FAIL rstlock_gnt got %b exp 1", m0_gnt);
    end
    step();
    rst = 1'b1;
    clear_reqs();
    mem_rdata = 32'hCAFE_F00D;
    #3;
    cmp++; if ({m0_rvalid, m1_rvalid, mem_req, m0_rdata} !== '0) begin
      err++; $display("FAIL rstlock_during got %h exp 0", {m0_rvalid, m1_rvalid, mem_req, m0_rdata});
    end
    step();
    rst = 1'b0;
    #3;
    cmp++; if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, mem_req, mem_addr, m0_rdata} !== '0) begin
      err++; $display("FAIL rstlock_after got %h exp 0", {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, mem_req, mem_addr, m0_rdata});
    end
    step();
    set_m1(1, 0, 0, 32'h600, '0, 4'hF);
    #3;
    cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin
      err++; $display("FAIL rstlock_unlocked got %b exp 01", {m0_gnt, m1_gnt});
    end
    step();
    clear_reqs();
    step();
  endtask

  task automatic test_random();
    logic          act[2], we[2], lk[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [3:0]    bm[2];
    int            lock_owner = -1, wcnt = 0, pend = -1, win;
    logic          granted;
    logic [5:0]    exp_ctl;
    logic [67:0]   exp_fld;
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; we[m] = 0; lk[m] = 0; ad[m] = '0; wd[m] = '0; bm[m] = '0;
    end
    rst = 1'b1; clear_reqs();
    step();
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && $urandom_range(1, 0) == 1) begin
          act[m] = 1; we[m] = $urandom_range(1, 0); lk[m] = ($urandom_range(3, 0) == 0);
          ad[m] = $urandom; wd[m] = $urandom; bm[m] = $urandom_range(15, 0);
        end
      end
      set_m0(act[0], we[0], lk[0], ad[0], wd[0], bm[0]);
      set_m1(act[1], we[1], lk[1], ad[1], wd[1], bm[1]);
      mem_ready = ($urandom_range(3, 0) != 0);
      mem_rdata = $urandom;
      if (lock_owner >= 0) win = act[lock_owner] ? lock_owner : -1;
      else if (act[0] && act[1]) win = (GUARD && wcnt >= MAXW) ? 1 : 0;
      else if (act[0]) win = 0;
      else if (act[1]) win = 1;
      else win = -1;
      granted = (win >= 0) && mem_ready;
      exp_ctl = {granted && win == 0, granted && win == 1, pend == 0, pend == 1,
                 win >= 0, (win >= 0) ? we[(win >= 0) ? win : 0] : 1'b0};
      exp_fld = (win >= 0) ? {ad[win], wd[win], bm[win]} : '0;
      #3;
      cmp++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_req, mem_we} !== exp_ctl) begin
        err++; $display("FAIL rand_ctl_n%0d got %b exp %b", n,
                        {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_req, mem_we}, exp_ctl);
      end
      cmp++; if ({mem_addr, mem_wdata, mem_bmask} !== exp_fld) begin
        err++; $display("FAIL rand_fields_n%0d got %h exp %h", n, {mem_addr, mem_wdata, mem_bmask}, exp_fld);
      end
      cmp++; if (m0_rdata !== ((pend == 0) ? mem_rdata : '0) || m1_rdata !== ((pend == 1) ? mem_rdata : '0)) begin
        err++; $display("FAIL rand_rdata_n%0d got d0=%h d1=%h exp owner=%0d data=%h", n, m0_rdata, m1_rdata, pend, mem_rdata);
      end
      if (lock_owner < 0 && act[1] && !(granted && win == 1) && wcnt < 255) wcnt++;
      if (granted && win == 1) wcnt = 0;
      pend = -1;
      if (granted) begin
        if (!we[win]) pend = win;
        lock_owner = lk[win] ? win : -1;
        act[win] = 0;
      end
      step();
    end
    clear_reqs();
    step();
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    clear_reqs();
    test_reset();
    test_single_read();
    test_priority();
    test_ready_stall();
    test_lock();
    test_alternate();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares the processor's single data-memory/IO port between the core load-store unit (master 0) and a debug/DMA master (master 1). It selects one request per cycle, forwards it to the memory/peripheral bus, and routes the fixed one-cycle read response back to the owner. It also supports locked read-modify-write sequences. It sits between the LSU stage and the data memory / output-port decoder.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-mask width is `DATA_W/8`.
- `MAX_WAIT`, default 8: starvation threshold in cycles, range 1..255. Used only when the guard is compiled in.

- `clk_i` in 1: single clock; all state changes on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `m0_req_i`, `m1_req_i` in 1: request; held with stable fields until granted.
- `m0_we_i`, `m1_we_i` in 1: 1 = write, 0 = read.
- `m0_lock_i`, `m1_lock_i` in 1: keep ownership after this transfer.
- `m0_addr_i`, `m1_addr_i` in `ADDR_W`: address.
- `m0_wdata_i`, `m1_wdata_i` in `DATA_W`: write data.
- `m0_bmask_i`, `m1_bmask_i` in `DATA_W/8`: byte enables.
- `m0_gnt_o`, `m1_gnt_o` out 1: transfer accepted this cycle.
- `m0_rvalid_o`, `m1_rvalid_o` out 1: read data valid.
- `m0_rdata_o`, `m1_rdata_o` out `DATA_W`: read data; forced to 0 when the matching rvalid is 0.
- `mem_req_o` out 1: request to memory.
- `mem_we_o` out 1: write enable.
- `mem_addr_o` out `ADDR_W`: address.
- `mem_wdata_o` out `DATA_W`: write data.
- `mem_bmask_o` out `DATA_W/8`: byte enables.
- `mem_ready_i` in 1: memory accepts the request this cycle.
- `mem_rdata_i` in `DATA_W`: read data, valid exactly 1 cycle after an accepted read.

## Operation
FSM states:
- `ARB`: pick a winner among the active requests.
  - Only one master requesting: that master wins.
  - Both requesting: M0 wins (fixed priority), except under the starvation rule in Configuration.
- `LOCK_M0` / `LOCK_M1`: only the lock owner may be selected. The other master's gnt stays 0 even if it requests.

Selection and grant:
- The winner's fields drive `mem_*`; `mem_req_o` = winner exists.
- If no request, `mem_*` fields are 0.
- `mX_gnt_o` = selected & `mem_req_o` & `mem_ready_i`, combinational.
- `mem_ready_i`=0: no gnt; selection is re-evaluated next cycle.

State transitions (evaluated on a granted transfer by master X):
- `lock_i`=1 → next state `LOCK_MX`.
- `lock_i`=0 → next state `ARB`.
- No grant → state holds.

Read response:
- A granted read registers `pend_valid`=1 and `pend_owner`=X.
- Next cycle: `mX_rvalid_o`=1 and `mX_rdata_o`=`mem_rdata_i`.
- Back-to-back reads are legal, one per cycle, with no bubble.
- Writes produce no response.

## Timing
- Grant latency: 0 cycles; gnt is asserted in the request cycle when ready and selected.
- Read data latency: 1 cycle after gnt.
- Reset values: state `ARB`, `pend_valid`=0, starvation counter 0. All gnt/rvalid/rdata/`mem_*` outputs are 0 during and after reset until a request is presented.
- Reset mid-lock or mid-read: lock is dropped and any pending rvalid is discarded (no response after reset).
- Simultaneous locked requests in `ARB`: the winner takes the lock; the loser waits until the owner's unlocked transfer.
- The lock owner deasserting req while locked: state holds and the other master stays blocked. This is intentional; the owner must finish with an unlocked transfer.
- One transaction per cycle maximum; no outstanding-transaction queue beyond the single `pend` register.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A saturating counter `wait_cnt` increments each cycle M1 requests in `ARB` and is not granted.
  - It clears to 0 on any M1 grant.
  - When `wait_cnt` ≥ `MAX_WAIT`, M1 beats M0 in `ARB`; the guard never overrides a lock.
- Not defined: no counter is built and M0 has strict priority. M1 can starve indefinitely.

## Test plan
- M0 read 0x1000 with `mem_ready_i`=1 and `mem_rdata_i`=0xDEADBEEF the next cycle → `m0_gnt_o`=1 in cycle 0, `m0_rvalid_o`=1 with rdata 0xDEADBEEF in cycle 1, `m1_rvalid_o`=0.
- M0 and M1 both request reads, held with ready=1, guard off → M0 granted every cycle and M1 never granted. With the guard on and `MAX_WAIT`=4 → M1 granted in cycle 4, then counter returns to 0.
- `mem_ready_i`=0 for 3 cycles with M1 write 0x2000 data 0x55 mask 0xF → no gnt, `mem_req_o`=1 and fields stable. Ready=1 in cycle 3 → gnt in cycle 3.
- M1 locked read then unlocked write while M0 requests throughout → M0 gnt=0 until the cycle after M1's unlocked write; state returns to `ARB`; M0 granted next.
- Alternating reads M0, M1, M0 on consecutive cycles (single requesters) → rvalid routed to the correct master each following cycle, with rdata matching `mem_rdata_i`.
- Assert `rst_i` in the cycle after a granted read while in `LOCK_M0` → no rvalid, state `ARB`, all outputs 0 the cycle after reset.
